// File: rtl/x_top_mem_bridge.sv
// Purpose : UART memory bridge; serialises a core read/strobed-write request to a host and returns data/ack.
// Latency : write (2+AB+DB) tx frames + 1 rx frame + 2 cycles; read (1+AB) tx frames + DB rx frames + 2 cycles.
// Backpr. : request held on i_valid until the o_accept pulse; tx bytes advance only when the UART tx finishes a frame.
//
// Ports:
//   i_clk, i_nrst          clock, asynchronous active-low reset
//   i_valid/i_rnw/i_addr   request handshake, direction and address (stable until o_accept)
//   i_data/i_strb          write data and byte strobes
//   o_accept/o_err/o_data  one-cycle completion pulse, error flag, read data
//   i_rx/o_tx              UART lines to the host

// UART transmitter: 8N1, LSB first. tx_accept pulses in the last cycle of the stop bit,
// so the bridge sees a byte as consumed only once its frame has fully left the line.
module x_top_mem_bridge_uart_tx #(
   parameter int p_cpb = 10
) (
   input  logic       i_clk,
   input  logic       i_nrst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_accept,
   output logic       o_tx
);
   localparam int CKW = (p_cpb > 1) ? $clog2(p_cpb) : 1;
   localparam logic [CKW-1:0] CK_LAST = CKW'(p_cpb - 1);

   logic           busy;
   logic [CKW-1:0] clk_cnt;
   logic [3:0]     bit_idx;
   logic [8:0]     shreg;

   assign tx_accept = busy && (clk_cnt == CK_LAST) && (bit_idx == 4'd9);

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         busy    <= 1'b0;
         clk_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '1;
         o_tx    <= 1'b1;
      end else if (!busy) begin
         if (tx_valid) begin
            busy    <= 1'b1;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= {1'b1, tx_data};
            o_tx    <= 1'b0;
         end
      end else if (clk_cnt == CK_LAST) begin
         clk_cnt <= '0;
         if (bit_idx == 4'd9) begin
            busy <= 1'b0;
         end else begin
            o_tx    <= shreg[0];
            shreg   <= {1'b1, shreg[8:1]};
            bit_idx <= bit_idx + 4'd1;
         end
      end else begin
         clk_cnt <= clk_cnt + CKW'(1);
      end
   end
endmodule

// UART receiver: 8N1, samples mid-bit; rx_valid pulses for one cycle mid stop bit
// when the stop bit reads high (framing errors are dropped silently).
module x_top_mem_bridge_uart_rx #(
   parameter int p_cpb = 10
) (
   input  logic       i_clk,
   input  logic       i_nrst,
   input  logic       i_rx,
   output logic       rx_valid,
   output logic [7:0] rx_data
);
   localparam int CKW = (p_cpb > 1) ? $clog2(p_cpb) : 1;
   localparam logic [CKW-1:0] CK_LAST = CKW'(p_cpb - 1);
   localparam logic [CKW-1:0] CK_HALF = CKW'(p_cpb / 2 - 1);

   logic [1:0]     sync;
   logic           busy;
   logic [CKW-1:0] clk_cnt;
   logic [3:0]     bit_idx;
   logic           rx_s;

   assign rx_s = sync[1];

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         sync     <= 2'b11;
         busy     <= 1'b0;
         clk_cnt  <= '0;
         bit_idx  <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         sync     <= {sync[0], i_rx};
         rx_valid <= 1'b0;
         if (!busy) begin
            if (!rx_s) begin
               busy    <= 1'b1;
               clk_cnt <= '0;
               bit_idx <= '0;
            end
         end else if (bit_idx == 4'd0) begin
            // re-check the start bit at its midpoint to reject glitches
            if (clk_cnt == CK_HALF) begin
               clk_cnt <= '0;
               if (rx_s) busy <= 1'b0;
               else      bit_idx <= 4'd1;
            end else begin
               clk_cnt <= clk_cnt + CKW'(1);
            end
         end else if (clk_cnt == CK_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd9) begin
               busy     <= 1'b0;
               rx_valid <= rx_s;
            end else begin
               rx_data <= {rx_s, rx_data[7:1]};
               bit_idx <= bit_idx + 4'd1;
            end
         end else begin
            clk_cnt <= clk_cnt + CKW'(1);
         end
      end
   end
endmodule

module x_top_mem_bridge #(
   parameter int         p_clk_hz     = 1000000,
   parameter int         p_baud       = 9600,
   parameter int         p_timeout    = 100000,
   parameter int         p_addr_bytes = 4,
   parameter int         p_data_bytes = 4,
   parameter logic [7:0] p_ack        = 8'hA5
) (
   input  logic                      i_clk,
   input  logic                      i_nrst,
   input  logic                      i_valid,
   input  logic                      i_rnw,
   input  logic [8*p_addr_bytes-1:0] i_addr,
   input  logic [8*p_data_bytes-1:0] i_data,
   input  logic [p_data_bytes-1:0]   i_strb,
   output logic                      o_accept,
   output logic                      o_err,
   output logic [8*p_data_bytes-1:0] o_data,
   input  logic                      i_rx,
   output logic                      o_tx
);
   localparam int CPB  = p_clk_hz / p_baud;
   localparam int MAXB = (p_addr_bytes > p_data_bytes) ? p_addr_bytes : p_data_bytes;
   localparam int CW   = $clog2(MAXB + 1);
   localparam int TW   = $clog2(p_timeout + 1);
   localparam logic [CW-1:0] AB_LAST = CW'(p_addr_bytes - 1);
   localparam logic [CW-1:0] DB_LAST = CW'(p_data_bytes - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(p_timeout - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_TX_CMD, S_TX_ADDR, S_TX_STRB, S_TX_DATA, S_RX_ACK, S_RX_DATA, S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] byte_cnt;
   logic [TW-1:0] to_cnt;
   logic          tx_valid;
   logic [7:0]    tx_byte;
   logic          tx_accept;
   logic          rx_valid;
   logic [7:0]    rx_byte;

   x_top_mem_bridge_uart_tx #(.p_cpb(CPB)) u_tx (
      .i_clk     (i_clk),
      .i_nrst    (i_nrst),
      .tx_valid  (tx_valid),
      .tx_data   (tx_byte),
      .tx_accept (tx_accept),
      .o_tx      (o_tx)
   );

   x_top_mem_bridge_uart_rx #(.p_cpb(CPB)) u_rx (
      .i_clk    (i_clk),
      .i_nrst   (i_nrst),
      .i_rx     (i_rx),
      .rx_valid (rx_valid),
      .rx_data  (rx_byte)
   );

   // Outgoing byte selection; the request fields are held stable by the core.
   always_comb begin
      tx_valid = 1'b0;
      tx_byte  = 8'h00;
      case (state)
         S_TX_CMD: begin
            tx_valid = 1'b1;
            tx_byte  = i_rnw ? 8'hF0 : 8'h0F;
         end
         S_TX_ADDR: begin
            tx_valid = 1'b1;
            for (int b = 0; b < p_addr_bytes; b++)
               if (byte_cnt == CW'(b)) tx_byte = i_addr[8*b +: 8];
         end
         S_TX_STRB: begin
            tx_valid = 1'b1;
            tx_byte  = 8'(i_strb);
         end
         S_TX_DATA: begin
            tx_valid = 1'b1;
            for (int b = 0; b < p_data_bytes; b++)
               if (byte_cnt == CW'(b)) tx_byte = i_data[8*b +: 8];
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state    <= S_IDLE;
         byte_cnt <= '0;
         to_cnt   <= '0;
         o_accept <= 1'b0;
         o_err    <= 1'b0;
         o_data   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_valid) begin
                  state    <= S_TX_CMD;
                  byte_cnt <= '0;
               end
            end
            S_TX_CMD: begin
               if (tx_accept) begin
                  state    <= S_TX_ADDR;
                  byte_cnt <= '0;
               end
            end
            S_TX_ADDR: begin
               if (tx_accept) begin
                  if (byte_cnt == AB_LAST) begin
                     state    <= i_rnw ? S_RX_DATA : S_TX_STRB;
                     byte_cnt <= '0;
                     to_cnt   <= '0;
                  end else begin
                     byte_cnt <= byte_cnt + CW'(1);
                  end
               end
            end
            S_TX_STRB: begin
               if (tx_accept) begin
                  state    <= S_TX_DATA;
                  byte_cnt <= '0;
               end
            end
            S_TX_DATA: begin
               if (tx_accept) begin
                  if (byte_cnt == DB_LAST) begin
                     state    <= S_RX_ACK;
                     byte_cnt <= '0;
                     to_cnt   <= '0;
                  end else begin
                     byte_cnt <= byte_cnt + CW'(1);
                  end
               end
            end
            S_RX_DATA: begin
               // a byte arriving on the expiry cycle still counts
               if (rx_valid) begin
                  to_cnt <= '0;
                  for (int b = 0; b < p_data_bytes; b++)
                     if (byte_cnt == CW'(b)) o_data[8*b +: 8] <= rx_byte;
                  if (byte_cnt == DB_LAST) begin
                     state    <= S_DONE;
                     byte_cnt <= '0;
                     o_accept <= 1'b1;
                     o_err    <= 1'b0;
                  end else begin
                     byte_cnt <= byte_cnt + CW'(1);
                  end
               end else if (to_cnt == TO_LAST) begin
                  state    <= S_DONE;
                  byte_cnt <= '0;
                  o_accept <= 1'b1;
                  o_err    <= 1'b1;
                  o_data   <= '0;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            S_RX_ACK: begin
               if (rx_valid) begin
                  state    <= S_DONE;
                  byte_cnt <= '0;
                  to_cnt   <= '0;
                  o_accept <= 1'b1;
                  o_err    <= (rx_byte != p_ack);
               end else if (to_cnt == TO_LAST) begin
                  state    <= S_DONE;
                  byte_cnt <= '0;
                  o_accept <= 1'b1;
                  o_err    <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            S_DONE: begin
               state    <= S_IDLE;
               byte_cnt <= '0;
               o_accept <= 1'b0;
               o_err    <= 1'b0;
            end
            default: begin
               state    <= S_IDLE;
               byte_cnt <= '0;
            end
         endcase
      end
   end
endmodule
